mso_trigger_hub: RTL and testbench
==================================

Name: mso_trigger_hub

Overview:
Trigger qualification hub for the MSO capture path. Combines up to NUM_TRIGGERS trigger sources, filtered by a per-source mask, into one capture trigger. The hub arms on request, can wait a programmable holdoff, then fires once on the first qualifying edge. It stays triggered until the next soft reset. It sits between the channel trigger comparators and the capture/storage controller.

Parameters:
NUM_TRIGGERS, 1, number of trigger source inputs (1..32).
HOLDOFF_WIDTH, 16, width of the holdoff cycle count.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst_n  input  1  synchronous active-low reset.
arm  input  1  single-cycle or level request to arm; acted on only in IDLE.
reset  input  1  synchronous soft reset of the trigger state (active high).
triggers  input  NUM_TRIGGERS  trigger source levels, already synchronous to clk.
mask  input  NUM_TRIGGERS  1 = source enabled.
mode  input  1  0 = OR (any enabled source edge), 1 = AND (all enabled sources high, rising).
holdoff  input  HOLDOFF_WIDTH  cycles to wait after arm before accepting events; sampled at arm.
armed  output  1  high while in ARMED.
triggered  output  1  high while in TRIGGERED.
trigger_pulse  output  1  one-cycle pulse on the transition into TRIGGERED.
trigger_source  output  NUM_TRIGGERS  masked edge vector that caused the trigger; held until reset.

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, synchronous and active-low.
- On rst_n=0:
  - state=IDLE.
  - All outputs 0.
  - Edge history trig_q=0.
  - Holdoff counter=0.
- All outputs are registered.
- trig_q <= triggers on every edge, in every state.
- Combinational qualification (pre-edge values):
  - m = triggers & mask.
  - rise = m & ~trig_q.
- Event in OR mode: |rise.
- Event in AND mode:
  - mask != 0, AND (m == mask), AND NOT ((trig_q & mask) == mask).
  - i.e. the rising edge of the all-enabled-high condition.
- mask == 0: no event in either mode.
- State machine (IDLE, HOLDOFF, ARMED, TRIGGERED):
  - IDLE: if arm and holdoff == 0 -> ARMED. If arm and holdoff = H > 0 -> HOLDOFF, with counter loaded H-1.
  - HOLDOFF: counter decrements each cycle; when counter == 0 -> ARMED. Events are ignored.
  - ARMED: on event -> TRIGGERED; trigger_pulse=1 for exactly that next cycle; trigger_source <= rise (OR mode) or mask (AND mode).
  - TRIGGERED: held indefinitely. trigger_pulse returns to 0 after one cycle.
- arm outside IDLE is ignored (no re-arm, no restart of holdoff).
- reset (soft), any state:
  - Next state IDLE; armed, triggered, trigger_pulse, trigger_source cleared; counter cleared.
  - reset has priority over arm and over an event in the same cycle.
  - trig_q still updates during reset.
- rst_n has priority over reset.
- Latency:
  - arm sampled at edge k with holdoff 0 -> armed=1 after edge k.
  - With holdoff H -> armed=1 after edge k+H.
  - An event sampled at edge j while ARMED -> triggered=1 and trigger_pulse=1 after edge j.
- A source already high when the hub becomes ARMED does not fire; a fresh 0->1 transition is required.
- Changing mask or mode while ARMED takes effect immediately (combinational qualification).
- Changing holdoff outside the arm cycle has no effect on a holdoff already running.

Test Plan:
1. rst_n=0 for 10 cycles with arm=1 and triggers toggling -> armed=triggered=trigger_pulse=0, trigger_source=0 throughout.
2. NUM_TRIGGERS=1, mask=1, mode=0, holdoff=0: pulse arm, then 3 cycles later triggers 0->1 -> armed=1 the cycle after arm; triggered=1 and trigger_pulse=1 for one cycle after the edge; trigger_source=1; a second edge produces no further pulse.
3. triggers held at 1 before arm, mask=1 -> no trigger after arming. Drive triggers 0 then 1 -> trigger fires.
4. holdoff=5: arm at edge k; trigger edges at k+2 ignored -> armed rises after edge k+5; a trigger edge at k+7 fires.
5. NUM_TRIGGERS=4, mode=1, mask=4'b0101:
   - raise bit0, then bit2 two cycles later -> fires on the bit2 edge with trigger_source=4'b0101.
   - toggling bit1 alone -> never fires.
   - mask=0 -> never fires.
6. reset asserted in the same cycle as a qualifying event while ARMED -> state IDLE, triggered=0, no trigger_pulse. A subsequent arm re-arms normally.

Source files
------------

// File: rtl/mso_trigger_hub.sv
// rtl/mso_trigger_hub.sv - trigger qualification hub: masked OR/AND edge detect,
// arm with programmable holdoff, single-shot capture trigger.
module mso_trigger_hub #(
  parameter int NUM_TRIGGERS  = 1,
  parameter int HOLDOFF_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     arm,
  input  logic                     reset,
  input  logic [NUM_TRIGGERS-1:0]  triggers,
  input  logic [NUM_TRIGGERS-1:0]  mask,
  input  logic                     mode,
  input  logic [HOLDOFF_WIDTH-1:0] holdoff,
  output logic                     armed,
  output logic                     triggered,
  output logic                     trigger_pulse,
  output logic [NUM_TRIGGERS-1:0]  trigger_source
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_HOLDOFF   = 2'd1,
    S_ARMED     = 2'd2,
    S_TRIGGERED = 2'd3
  } state_t;

  localparam logic [HOLDOFF_WIDTH-1:0] CNT_ONE = {{(HOLDOFF_WIDTH-1){1'b0}}, 1'b1};

  state_t                   state_q, state_d;
  logic [NUM_TRIGGERS-1:0]  trig_q, trig_d;
  logic [HOLDOFF_WIDTH-1:0] cnt_q, cnt_d;
  logic                     armed_q, armed_d;
  logic                     triggered_q, triggered_d;
  logic                     pulse_q, pulse_d;
  logic [NUM_TRIGGERS-1:0]  src_q, src_d;

  logic [NUM_TRIGGERS-1:0]  m;
  logic [NUM_TRIGGERS-1:0]  rise;
  logic                     or_event;
  logic                     and_event;
  logic                     event_hit;

  // AND mode fires on the rising edge of "all enabled sources high", not on any single edge
  always_comb begin
    m         = triggers & mask;
    rise      = m & ~trig_q;
    or_event  = |rise;
    and_event = (|mask) && (m == mask) && ((trig_q & mask) != mask);
    event_hit = mode ? and_event : or_event;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    pulse_d = 1'b0;
    trig_d  = triggers;
    if (reset) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      src_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (arm) begin
            if (holdoff == '0) begin
              state_d = S_ARMED;
            end else begin
              state_d = S_HOLDOFF;
              cnt_d   = holdoff - CNT_ONE;
            end
          end
        end
        S_HOLDOFF: begin
          if (cnt_q == '0) begin
            state_d = S_ARMED;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        S_ARMED: begin
          if (event_hit) begin
            state_d = S_TRIGGERED;
            pulse_d = 1'b1;
            src_d   = mode ? mask : rise;
          end
        end
        default: begin
          state_d = S_TRIGGERED;
        end
      endcase
    end
    armed_d     = (state_d == S_ARMED);
    triggered_d = (state_d == S_TRIGGERED);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      trig_q      <= '0;
      cnt_q       <= '0;
      armed_q     <= 1'b0;
      triggered_q <= 1'b0;
      pulse_q     <= 1'b0;
      src_q       <= '0;
    end else begin
      state_q     <= state_d;
      trig_q      <= trig_d;
      cnt_q       <= cnt_d;
      armed_q     <= armed_d;
      triggered_q <= triggered_d;
      pulse_q     <= pulse_d;
      src_q       <= src_d;
    end
  end

  assign armed          = armed_q;
  assign triggered      = triggered_q;
  assign trigger_pulse  = pulse_q;
  assign trigger_source = src_q;

endmodule

// File: tb/tb_mso_trigger_hub.sv
// tb/tb_mso_trigger_hub.sv - directed bench for mso_trigger_hub (1-source and 4-source instances).
module tb_mso_trigger_hub;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        arm;
  logic        reset;
  logic        mode;
  logic [15:0] holdoff;
  logic [0:0]  t1, k1;
  logic [3:0]  t4, k4;
  logic        armed1, trig1, pulse1;
  logic [0:0]  src1;
  logic        armed4, trig4, pulse4;
  logic [3:0]  src4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mso_trigger_hub #(.NUM_TRIGGERS(1), .HOLDOFF_WIDTH(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .arm(arm), .reset(reset),
    .triggers(t1), .mask(k1), .mode(mode), .holdoff(holdoff),
    .armed(armed1), .triggered(trig1), .trigger_pulse(pulse1), .trigger_source(src1)
  );

  mso_trigger_hub #(.NUM_TRIGGERS(4), .HOLDOFF_WIDTH(16)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .arm(arm), .reset(reset),
    .triggers(t4), .mask(k4), .mode(mode), .holdoff(holdoff),
    .armed(armed4), .triggered(trig4), .trigger_pulse(pulse4), .trigger_source(src4)
  );

  typedef struct {
    logic       reset;
    logic       arm;
    logic       mode;
    logic [3:0] trig;
    logic [3:0] mask;
    logic       e_armed;
    logic       e_trig;
    logic       e_pulse;
    logic [3:0] e_src;
  } vec_t;

  vec_t vecs[26];

  function automatic vec_t mk(input logic r, input logic a, input logic md,
                              input logic [3:0] tr, input logic [3:0] mk_,
                              input logic ea, input logic et, input logic ep,
                              input logic [3:0] es);
    vec_t v;
    v.reset = r; v.arm = a; v.mode = md; v.trig = tr; v.mask = mk_;
    v.e_armed = ea; v.e_trig = et; v.e_pulse = ep; v.e_src = es;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check1(input string tag, input logic a, input logic t, input logic p, input logic s);
    check({tag, ".armed1"}, {31'd0, armed1}, {31'd0, a});
    check({tag, ".triggered1"}, {31'd0, trig1}, {31'd0, t});
    check({tag, ".pulse1"}, {31'd0, pulse1}, {31'd0, p});
    check({tag, ".src1"}, {31'd0, src1}, {31'd0, s});
  endtask

  task automatic check4(input string tag, input logic a, input logic t, input logic p, input logic [3:0] s);
    check({tag, ".armed4"}, {31'd0, armed4}, {31'd0, a});
    check({tag, ".triggered4"}, {31'd0, trig4}, {31'd0, t});
    check({tag, ".pulse4"}, {31'd0, pulse4}, {31'd0, p});
    check({tag, ".src4"}, {28'd0, src4}, {28'd0, s});
  endtask

  initial begin
    // AND/OR qualification on the 4-source instance; each row is one clock
    //            rst arm md trig     mask     arm trg pls src
    vecs[0]  = mk(1, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000);
    vecs[1]  = mk(0, 1, 1, 4'b0000, 4'b0101, 1, 0, 0, 4'b0000);
    vecs[2]  = mk(0, 0, 1, 4'b0001, 4'b0101, 1, 0, 0, 4'b0000);
    vecs[3]  = mk(0, 0, 1, 4'b0001, 4'b0101, 1, 0, 0, 4'b0000);
    vecs[4]  = mk(0, 0, 1, 4'b0101, 4'b0101, 0, 1, 1, 4'b0101);
    vecs[5]  = mk(0, 0, 1, 4'b0101, 4'b0101, 0, 1, 0, 4'b0101);
    vecs[6]  = mk(0, 1, 1, 4'b0000, 4'b0101, 0, 1, 0, 4'b0101);
    vecs[7]  = mk(1, 0, 1, 4'b0000, 4'b0101, 0, 0, 0, 4'b0000);
    vecs[8]  = mk(0, 1, 1, 4'b0000, 4'b0101, 1, 0, 0, 4'b0000);
    vecs[9]  = mk(0, 0, 1, 4'b0010, 4'b0101, 1, 0, 0, 4'b0000);
    vecs[10] = mk(0, 0, 1, 4'b0000, 4'b0101, 1, 0, 0, 4'b0000);
    vecs[11] = mk(0, 0, 1, 4'b0010, 4'b0101, 1, 0, 0, 4'b0000);
    vecs[12] = mk(0, 0, 1, 4'b1010, 4'b0101, 1, 0, 0, 4'b0000);
    vecs[13] = mk(0, 0, 1, 4'b1111, 4'b0000, 1, 0, 0, 4'b0000);
    vecs[14] = mk(0, 0, 1, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000);
    vecs[15] = mk(0, 0, 1, 4'b0101, 4'b0000, 1, 0, 0, 4'b0000);
    vecs[16] = mk(0, 0, 0, 4'b0101, 4'b0101, 1, 0, 0, 4'b0000);
    vecs[17] = mk(0, 0, 0, 4'b0100, 4'b0101, 1, 0, 0, 4'b0000);
    vecs[18] = mk(0, 0, 0, 4'b0101, 4'b0101, 0, 1, 1, 4'b0001);
    vecs[19] = mk(1, 0, 0, 4'b0000, 4'b0101, 0, 0, 0, 4'b0000);
    vecs[20] = mk(0, 1, 0, 4'b0000, 4'b1111, 1, 0, 0, 4'b0000);
    vecs[21] = mk(1, 0, 0, 4'b0011, 4'b1111, 0, 0, 0, 4'b0000);
    vecs[22] = mk(0, 0, 0, 4'b0011, 4'b1111, 0, 0, 0, 4'b0000);
    vecs[23] = mk(0, 1, 0, 4'b0011, 4'b1111, 1, 0, 0, 4'b0000);
    vecs[24] = mk(0, 0, 0, 4'b0111, 4'b1111, 0, 1, 1, 4'b0100);
    vecs[25] = mk(0, 0, 0, 4'b0111, 4'b1111, 0, 1, 0, 4'b0100);

    rst_n = 1'b0; arm = 1'b1; reset = 1'b0; mode = 1'b0; holdoff = 16'd0;
    t1 = 1'b0; k1 = 1'b1; t4 = 4'b0000; k4 = 4'b1111;

    // hard reset dominates arm and toggling sources
    for (int i = 0; i < 10; i++) begin
      t1 = ~t1; t4 = ~t4;
      step();
      check1("hard_reset", 0, 0, 0, 0);
      check4("hard_reset", 0, 0, 0, 4'b0000);
    end
    arm = 1'b0; t1 = 1'b0; t4 = 4'b0000;
    rst_n = 1'b1;
    step();
    check1("post_reset", 0, 0, 0, 0);

    // single source, OR mode, no holdoff
    k1 = 1'b1; mode = 1'b0; holdoff = 16'd0;
    arm = 1'b1; step(); arm = 1'b0;
    check1("basic_arm", 1, 0, 0, 0);
    step(); check1("basic_wait1", 1, 0, 0, 0);
    step(); check1("basic_wait2", 1, 0, 0, 0);
    t1 = 1'b1; step(); check1("basic_fire", 0, 1, 1, 1);
    step(); check1("basic_hold", 0, 1, 0, 1);
    t1 = 1'b0; step();
    t1 = 1'b1; step(); check1("basic_second_edge", 0, 1, 0, 1);

    // source already high at arm must not fire
    reset = 1'b1; step(); reset = 1'b0;
    check1("prehigh_reset", 0, 0, 0, 0);
    arm = 1'b1; step(); arm = 1'b0;
    check1("prehigh_arm", 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(); check1("prehigh_held", 1, 0, 0, 0);
    end
    t1 = 1'b0; step(); check1("prehigh_low", 1, 0, 0, 0);
    t1 = 1'b1; step(); check1("prehigh_fire", 0, 1, 1, 1);

    // holdoff 5: edge during holdoff ignored, armed after edge k+5
    reset = 1'b1; t1 = 1'b0; step(); reset = 1'b0;
    holdoff = 16'd5; arm = 1'b1; step();
    arm = 1'b0; holdoff = 16'd0;
    check1("hold_k", 0, 0, 0, 0);
    step(); check1("hold_k1", 0, 0, 0, 0);
    t1 = 1'b1; arm = 1'b1; step(); check1("hold_k2_edge", 0, 0, 0, 0);
    t1 = 1'b0; arm = 1'b0; step(); check1("hold_k3", 0, 0, 0, 0);
    step(); check1("hold_k4", 0, 0, 0, 0);
    step(); check1("hold_k5_armed", 1, 0, 0, 0);
    step(); check1("hold_k6", 1, 0, 0, 0);
    t1 = 1'b1; step(); check1("hold_k7_fire", 0, 1, 1, 1);

    // holdoff 1 boundary: armed one edge later than holdoff 0
    reset = 1'b1; t1 = 1'b0; step(); reset = 1'b0;
    holdoff = 16'd1; arm = 1'b1; step(); arm = 1'b0; holdoff = 16'd0;
    check1("hold1_k", 0, 0, 0, 0);
    step(); check1("hold1_k1", 1, 0, 0, 0);

    // table-driven 4-source sequences
    k1 = 1'b0;
    for (int i = 0; i < 26; i++) begin
      reset = vecs[i].reset; arm = vecs[i].arm; mode = vecs[i].mode;
      t4 = vecs[i].trig; k4 = vecs[i].mask;
      step();
      check4($sformatf("vec%0d", i), vecs[i].e_armed, vecs[i].e_trig,
             vecs[i].e_pulse, vecs[i].e_src);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
